// File: rtl/alu_ctrl_pkg.sv
// Shared opcode, condition, flag-index and FSM-state definitions for the
// data-processing ALU sequencing controller.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_EOR = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_RSB = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SBC = 5'b00110;
    localparam logic [4:0] OP_RSC = 5'b00111;
    localparam logic [4:0] OP_TST = 5'b01000;
    localparam logic [4:0] OP_TEQ = 5'b01001;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_CMN = 5'b01011;
    localparam logic [4:0] OP_ORR = 5'b01100;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam logic [4:0] OP_BIC = 5'b01110;
    localparam logic [4:0] OP_MVN = 5'b01111;
    localparam logic [4:0] OP_OP1 = 5'b10000;
    localparam logic [4:0] OP_OP2 = 5'b10001;
    localparam logic [4:0] OP_OP3 = 5'b10010;
    localparam logic [4:0] OP_OP4 = 5'b10011;
    localparam logic [4:0] OP_OP5 = 5'b10100;
    localparam logic [4:0] OP_OP6 = 5'b10101;
    localparam logic [4:0] OP_OP7 = 5'b10110;
    localparam logic [4:0] OP_OP8 = 5'b10111;
    localparam logic [4:0] OP_OP9 = 5'b11000;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_COMMIT,
        ST_SKIP
    } state_t;

    // TST/TEQ/CMP/CMN: compare-only, always update flags, never write back.
    function automatic logic is_test_op(input logic [4:0] op);
        return (op[4:2] == 3'b010);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Request channel from the decode stage into the ALU sequencing controller.
interface alu_exec_ctrl_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cond;
    logic [4:0]       req_op;
    logic             req_s;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_rd;

    modport master (
        output req_valid, req_cond, req_op, req_s, req_a, req_b, req_rd,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_cond, req_op, req_s, req_a, req_b, req_rd,
        output req_ready
    );

endinterface

// File: rtl/alu_cond_eval.sv
// ARM condition-field evaluator: pass=1 when cond holds for flags {Z,N,V,C}.
module alu_cond_eval
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic z, n, v, c;

    always_comb begin
        z    = flags[FLAG_Z];
        n    = flags[FLAG_N];
        v    = flags[FLAG_V];
        c    = flags[FLAG_C];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencing controller for the 32-bit data-processing ALU: condition check,
// operand issue, result capture, write-back and Z/N/V/C flag ownership.
module alu_exec_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_ctrl_if.slave   req,
    output logic [4:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_r,
    input  logic [3:0]       alu_flag,
    output logic             wb_valid,
    output logic [3:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             cond_skip,
    output logic [3:0]       flags
);

    state_t           state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic [4:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [3:0]       rd_q, rd_d;
    logic             s_q, s_d;
    logic [3:0]       cap_flag_q, cap_flag_d;
    logic [3:0]       flags_q, flags_d;
    logic             wb_valid_q, wb_valid_d;
    logic [3:0]       wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             cond_skip_q, cond_skip_d;
    logic             cond_pass;

    alu_cond_eval u_cond (
        .cond  (req.req_cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_cin_d   = alu_cin_q;
        rd_d        = rd_q;
        s_d         = s_q;
        cap_flag_d  = cap_flag_q;
        flags_d     = flags_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        cond_skip_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    req_ready_d = 1'b0;
                    if (cond_pass) begin
                        state_d   = ST_EXEC;
                        alu_op_d  = req.req_op;
                        alu_a_d   = req.req_a;
                        alu_b_d   = req.req_b;
                        alu_cin_d = flags_q[FLAG_C];
                        rd_d      = req.req_rd;
                        s_d       = req.req_s;
                    end else begin
                        state_d     = ST_SKIP;
                        cond_skip_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                // Write-back registers double as the result capture so the
                // strobe, index and data all appear together in COMMIT.
                state_d    = ST_COMMIT;
                wb_valid_d = !is_test_op(alu_op_q);
                wb_rd_d    = rd_q;
                wb_data_d  = alu_r;
                cap_flag_d = alu_flag;
            end
            ST_COMMIT: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                if (!alu_op_q[4] && (s_q || is_test_op(alu_op_q)))
                    flags_d = cap_flag_q;
            end
            ST_SKIP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            rd_q        <= '0;
            s_q         <= 1'b0;
            cap_flag_q  <= '0;
            flags_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            cond_skip_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_cin_q   <= alu_cin_d;
            rd_q        <= rd_d;
            s_q         <= s_d;
            cap_flag_q  <= cap_flag_d;
            flags_q     <= flags_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            cond_skip_q <= cond_skip_d;
        end
    end

    assign req.req_ready = req_ready_q;
    assign alu_op        = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_cin       = alu_cin_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign cond_skip     = cond_skip_q;
    assign flags         = flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a stand-in combinational ALU.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_r;
    logic        alu_cin;
    logic [3:0]  alu_flag;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        cond_skip;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    alu_exec_ctrl_if #(.WIDTH(32)) rif ();

    alu_exec_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (rif),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_r     (alu_r),
        .alu_flag  (alu_flag),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .cond_skip (cond_skip),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: arithmetic forms give real carry/overflow, logical forms pass C=cin, V=0.
    logic [31:0] x, y;
    logic        ci, arith;
    logic [32:0] sum;
    logic [31:0] lres;
    always_comb begin
        x = alu_a; y = alu_b; ci = 1'b0; arith = 1'b1; lres = '0; sum = '0;
        case (alu_op)
            5'b00000, 5'b01000: begin arith = 1'b0; lres = alu_a & alu_b; end
            5'b00001, 5'b01001: begin arith = 1'b0; lres = alu_a ^ alu_b; end
            5'b00010, 5'b01010: begin y = ~alu_b; ci = 1'b1; end
            5'b00011:           begin x = alu_b; y = ~alu_a; ci = 1'b1; end
            5'b00100, 5'b01011: begin end
            5'b00101:           begin ci = alu_cin; end
            5'b00110:           begin y = ~alu_b; ci = alu_cin; end
            5'b00111:           begin x = alu_b; y = ~alu_a; ci = alu_cin; end
            5'b01100:           begin arith = 1'b0; lres = alu_a | alu_b; end
            5'b01101:           begin arith = 1'b0; lres = alu_b; end
            5'b01110:           begin arith = 1'b0; lres = alu_a & ~alu_b; end
            5'b01111:           begin arith = 1'b0; lres = ~alu_b; end
            5'b10001:           begin x = alu_b; y = 32'd4; end
            default:            begin end
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        if (arith) begin
            alu_r    = sum[31:0];
            alu_flag = {sum[31:0] == 32'd0, sum[31],
                        (x[31] == y[31]) && (sum[31] != x[31]), sum[32]};
        end else begin
            alu_r    = lres;
            alu_flag = {lres == 32'd0, lres[31], 1'b0, alu_cin};
        end
    end

    typedef struct {
        logic [3:0]  cond;
        logic [4:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        skip;
        logic        wb;
        logic [31:0] data;
        logic        cin;
        logic [3:0]  flg;
    } vec_t;

    vec_t tbl [15];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t r, input int idx);
        rif.req_valid = 1'b1;
        rif.req_cond  = r.cond;
        rif.req_op    = r.op;
        rif.req_s     = r.s;
        rif.req_a     = r.a;
        rif.req_b     = r.b;
        rif.req_rd    = r.rd;
        @(posedge clk); #1;
        rif.req_valid = 1'b0;
        chk($sformatf("v%0d ready_t1", idx), {31'd0, rif.req_ready}, 32'd0);
        chk($sformatf("v%0d skip_t1", idx), {31'd0, cond_skip}, {31'd0, r.skip});
        if (!r.skip) begin
            chk($sformatf("v%0d alu_op", idx), {27'd0, alu_op}, {27'd0, r.op});
            chk($sformatf("v%0d alu_a", idx), alu_a, r.a);
            chk($sformatf("v%0d alu_b", idx), alu_b, r.b);
            chk($sformatf("v%0d alu_cin", idx), {31'd0, alu_cin}, {31'd0, r.cin});
            chk($sformatf("v%0d wbv_t1", idx), {31'd0, wb_valid}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d wb_valid", idx), {31'd0, wb_valid}, {31'd0, r.wb});
            if (r.wb) begin
                chk($sformatf("v%0d wb_data", idx), wb_data, r.data);
                chk($sformatf("v%0d wb_rd", idx), {28'd0, wb_rd}, {28'd0, r.rd});
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d wbv_t3", idx), {31'd0, wb_valid}, 32'd0);
        end else begin
            @(posedge clk); #1;
            chk($sformatf("v%0d skip_t2", idx), {31'd0, cond_skip}, 32'd0);
            chk($sformatf("v%0d wbv_t2", idx), {31'd0, wb_valid}, 32'd0);
        end
        chk($sformatf("v%0d ready_done", idx), {31'd0, rif.req_ready}, 32'd1);
        chk($sformatf("v%0d flags", idx), {28'd0, flags}, {28'd0, r.flg});
    endtask

    initial begin
        //           cond   op        s     a             b             rd    skip  wb    data          cin   flags
        tbl[0]  = '{4'hE, 5'b00100, 1'b1, 32'h7F000000, 32'h0F001000, 4'd3, 1'b0, 1'b1, 32'h8E001000, 1'b0, 4'b0110};
        tbl[1]  = '{4'hE, 5'b01010, 1'b0, 32'h50000000, 32'hB0000000, 4'd1, 1'b0, 1'b0, 32'h0,        1'b0, 4'b0110};
        tbl[2]  = '{4'hE, 5'b01010, 1'b0, 32'h00000005, 32'h00000001, 4'd1, 1'b0, 1'b0, 32'h0,        1'b0, 4'b0001};
        tbl[3]  = '{4'hE, 5'b00101, 1'b0, 32'h005AC023, 32'h0DAE2310, 4'd5, 1'b0, 1'b1, 32'h0E08E334, 1'b1, 4'b0001};
        tbl[4]  = '{4'hE, 5'b10001, 1'b1, 32'h00000000, 32'hB0000000, 4'd7, 1'b0, 1'b1, 32'hB0000004, 1'b1, 4'b0001};
        tbl[5]  = '{4'h3, 5'b00010, 1'b1, 32'h00000009, 32'h00000001, 4'd2, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0001};
        tbl[6]  = '{4'h8, 5'b01101, 1'b0, 32'h00000000, 32'h12345678, 4'd2, 1'b0, 1'b1, 32'h12345678, 1'b1, 4'b0001};
        tbl[7]  = '{4'hE, 5'b01010, 1'b0, 32'h00000001, 32'h00000001, 4'd0, 1'b0, 1'b0, 32'h0,        1'b1, 4'b1001};
        tbl[8]  = '{4'h0, 5'b00100, 1'b0, 32'h00000001, 32'h00000002, 4'd4, 1'b0, 1'b1, 32'h00000003, 1'b1, 4'b1001};
        tbl[9]  = '{4'h1, 5'b00010, 1'b1, 32'h00000003, 32'h00000001, 4'd4, 1'b1, 1'b0, 32'h0,        1'b0, 4'b1001};
        tbl[10] = '{4'hE, 5'b00010, 1'b1, 32'h00000000, 32'h00000001, 4'd6, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b0100};
        tbl[11] = '{4'hB, 5'b01100, 1'b0, 32'h000000F0, 32'h0000000F, 4'd1, 1'b0, 1'b1, 32'h000000FF, 1'b0, 4'b0100};
        tbl[12] = '{4'hA, 5'b00100, 1'b1, 32'h00000001, 32'h00000001, 4'd1, 1'b1, 1'b0, 32'h0,        1'b0, 4'b0100};
        tbl[13] = '{4'hE, 5'b01011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 4'd1, 1'b0, 1'b0, 32'h0,        1'b0, 4'b1001};
        tbl[14] = '{4'hF, 5'b00100, 1'b1, 32'h00000001, 32'h00000001, 4'd1, 1'b1, 1'b0, 32'h0,        1'b0, 4'b1001};

        rif.req_valid = 1'b0; rif.req_cond = '0; rif.req_op = '0; rif.req_s = 1'b0;
        rif.req_a = '0; rif.req_b = '0; rif.req_rd = '0;
        reset = 1'b1;
        #12;
        chk("rst_ready", {31'd0, rif.req_ready}, 32'd1);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_cond_skip", {31'd0, cond_skip}, 32'd0);
        chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_req(tbl[i], i);

        // Idle with req_valid low: alu_* keep the last issued request
        repeat (3) @(posedge clk);
        #1;
        chk("idle_alu_a", alu_a, 32'hFFFFFFFF);
        chk("idle_alu_op", {27'd0, alu_op}, {27'd0, 5'b01011});
        chk("idle_ready", {31'd0, rif.req_ready}, 32'd1);
        chk("idle_flags", {28'd0, flags}, {28'd0, 4'b1001});

        // Reset during EXEC of a flag-setting ADD
        rif.req_valid = 1'b1; rif.req_cond = 4'hE; rif.req_op = 5'b00100; rif.req_s = 1'b1;
        rif.req_a = 32'h7F000000; rif.req_b = 32'h0F001000; rif.req_rd = 4'd9;
        @(posedge clk); #1;
        rif.req_valid = 1'b0;
        chk("abort_in_exec", {27'd0, alu_op}, {27'd0, 5'b00100});
        reset = 1'b1;
        #1;
        chk("abort_flags", {28'd0, flags}, 32'd0);
        chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("abort_ready", {31'd0, rif.req_ready}, 32'd1);
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_no_wb%0d", c), {31'd0, wb_valid}, 32'd0);
            chk($sformatf("abort_no_skip%0d", c), {31'd0, cond_skip}, 32'd0);
        end
        chk("abort_ready_after", {31'd0, rif.req_ready}, 32'd1);

        // Flags 0000: EQ and NV both skip
        v = '{4'h0, 5'b00010, 1'b1, 32'h5, 32'h5, 4'd2, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000};
        run_req(v, 100);
        v.cond = 4'hF;
        run_req(v, 101);
        // Normal completion after reset recovery
        v = '{4'hE, 5'b00100, 1'b1, 32'h7F000000, 32'h0F001000, 4'd9, 1'b0, 1'b1, 32'h8E001000, 1'b0, 4'b0110};
        run_req(v, 102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
